// File: rtl/bus_arbiter.sv
// bus_arbiter: grants a shared line bus to either the I-cache or the D-cache
// for one whole transaction (address beat, then a write-data or read-response
// burst of BEATS_PER_LINE beats), routing request/response paths to the owner.
// Optional feature: define ARB_ROUND_ROBIN_EN to alternate grants between
// simultaneous requesters; without it the D-cache always wins a tie.
module bus_arbiter #(
   parameter int BUS_DATA_WIDTH = 64,
   parameter int BUS_TAG_WIDTH  = 13,
   parameter int BEATS_PER_LINE = 8
) (
   input  logic                      clk,
   input  logic                      reset,
   // I-cache side
   input  logic                      i_reqcyc,
   input  logic                      i_respack,
   input  logic [BUS_DATA_WIDTH-1:0] i_req,
   input  logic [BUS_TAG_WIDTH-1:0]  i_reqtag,
   output logic                      i_reqack,
   output logic                      i_respcyc,
   output logic [BUS_DATA_WIDTH-1:0] i_resp,
   output logic [BUS_TAG_WIDTH-1:0]  i_resptag,
   // D-cache side
   input  logic                      d_reqcyc,
   input  logic                      d_respack,
   input  logic [BUS_DATA_WIDTH-1:0] d_req,
   input  logic [BUS_TAG_WIDTH-1:0]  d_reqtag,
   output logic                      d_reqack,
   output logic                      d_respcyc,
   output logic [BUS_DATA_WIDTH-1:0] d_resp,
   output logic [BUS_TAG_WIDTH-1:0]  d_resptag,
   // shared bus side
   output logic                      bus_reqcyc,
   output logic                      bus_respack,
   output logic [BUS_DATA_WIDTH-1:0] bus_req,
   output logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
   input  logic                      bus_reqack,
   input  logic                      bus_respcyc,
   input  logic [BUS_DATA_WIDTH-1:0] bus_resp,
   input  logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
   // status
   output logic                      owner,
   output logic                      busy
);

   localparam int               CNT_W     = (BEATS_PER_LINE > 1) ? $clog2(BEATS_PER_LINE) : 1;
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS_PER_LINE - 1);

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      WDATA,
      RESP
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic             owner_nxt;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;
   logic             grant;       // requester that wins if arbitration happens now

   // request path of whichever cache currently owns the bus
   logic                      own_reqcyc;
   logic                      own_respack;
   logic [BUS_DATA_WIDTH-1:0] own_req;
   logic [BUS_TAG_WIDTH-1:0]  own_reqtag;

   assign own_reqcyc  = owner ? d_reqcyc  : i_reqcyc;
   assign own_respack = owner ? d_respack : i_respack;
   assign own_req     = owner ? d_req     : i_req;
   assign own_reqtag  = owner ? d_reqtag  : i_reqtag;

   assign busy = (state != IDLE);

`ifdef ARB_ROUND_ROBIN_EN
   logic last_granted;

   // on a tie the requester that did not win last time gets the bus
   assign grant = (i_reqcyc && d_reqcyc) ? ~last_granted : d_reqcyc;

   // remember the winner of every arbitration; reset favours the I-cache next
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         last_granted <= 1'b1;
      end else if (state == IDLE && (i_reqcyc || d_reqcyc)) begin
         last_granted <= grant;
      end
   end
`else
   // fixed priority: the D-cache wins any tie
   assign grant = d_reqcyc;
`endif

   // state, owner and beat counter registers
   // NOTE: non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         owner <= 1'b0;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         owner <= owner_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // next-state logic and owner-only routing of the request/response paths
   always_comb begin
      // NOTE: every output gets a default first so no path can infer a latch.
      state_nxt   = state;
      owner_nxt   = owner;
      cnt_nxt     = cnt;
      bus_reqcyc  = 1'b0;
      bus_req     = '0;
      bus_reqtag  = '0;
      bus_respack = 1'b0;
      i_reqack    = 1'b0;
      i_respcyc   = 1'b0;
      i_resp      = '0;
      i_resptag   = '0;
      d_reqack    = 1'b0;
      d_respcyc   = 1'b0;
      d_resp      = '0;
      d_resptag   = '0;

      case (state)
         IDLE: begin
            // arbitration cycle: nothing is driven, only the grant is captured
            if (i_reqcyc || d_reqcyc) begin
               owner_nxt = grant;
               cnt_nxt   = '0;
               state_nxt = REQ;
            end
         end

         REQ, WDATA: begin
            bus_reqcyc = own_reqcyc;
            bus_req    = own_req;
            bus_reqtag = own_reqtag;
            if (owner) begin
               d_reqack = bus_reqack;
            end else begin
               i_reqack = bus_reqack;
            end

            if (state == REQ) begin
               if (!own_reqcyc) begin
                  // owner withdrew before the bus accepted: abandon quietly
                  state_nxt = IDLE;
               end else if (bus_reqack) begin
                  if (own_reqtag[BUS_TAG_WIDTH-1]) begin
                     state_nxt = RESP;
                     cnt_nxt   = '0;
                  end else begin
                     // the accepted address beat already carries write data beat 0
                     state_nxt = WDATA;
                     cnt_nxt   = CNT_W'(1);
                  end
               end
            end else if (own_reqcyc && bus_reqack) begin
               cnt_nxt = cnt + CNT_W'(1);
               if (cnt == LAST_BEAT) begin
                  state_nxt = IDLE;
               end
            end
         end

         RESP: begin
            bus_respack = own_respack;
            if (owner) begin
               d_respcyc = bus_respcyc;
               d_resp    = bus_resp;
               d_resptag = bus_resptag;
            end else begin
               i_respcyc = bus_respcyc;
               i_resp    = bus_resp;
               i_resptag = bus_resptag;
            end

            if (bus_respcyc && own_respack) begin
               cnt_nxt = cnt + CNT_W'(1);
               if (cnt == LAST_BEAT) begin
                  state_nxt = IDLE;
               end
            end
         end

         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed scenarios plus randomized traffic for bus_arbiter,
// every output compared each cycle against a transaction-level model.
// Compile with ARB_ROUND_ROBIN_EN defined to exercise the round-robin build.
module tb_bus_arbiter;

   localparam int DW    = 64;
   localparam int TW    = 13;
   localparam int BEATS = 8;
`ifdef ARB_ROUND_ROBIN_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          reset;
   logic          i_reqcyc, i_respack, i_reqack, i_respcyc;
   logic [DW-1:0] i_req, i_resp;
   logic [TW-1:0] i_reqtag, i_resptag;
   logic          d_reqcyc, d_respack, d_reqack, d_respcyc;
   logic [DW-1:0] d_req, d_resp;
   logic [TW-1:0] d_reqtag, d_resptag;
   logic          bus_reqcyc, bus_respack, bus_reqack, bus_respcyc;
   logic [DW-1:0] bus_req, bus_resp;
   logic [TW-1:0] bus_reqtag, bus_resptag;
   logic          owner, busy;

   bus_arbiter #(
      .BUS_DATA_WIDTH(DW),
      .BUS_TAG_WIDTH (TW),
      .BEATS_PER_LINE(BEATS)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .i_reqcyc   (i_reqcyc),
      .i_respack  (i_respack),
      .i_req      (i_req),
      .i_reqtag   (i_reqtag),
      .i_reqack   (i_reqack),
      .i_respcyc  (i_respcyc),
      .i_resp     (i_resp),
      .i_resptag  (i_resptag),
      .d_reqcyc   (d_reqcyc),
      .d_respack  (d_respack),
      .d_req      (d_req),
      .d_reqtag   (d_reqtag),
      .d_reqack   (d_reqack),
      .d_respcyc  (d_respcyc),
      .d_resp     (d_resp),
      .d_resptag  (d_resptag),
      .bus_reqcyc (bus_reqcyc),
      .bus_respack(bus_respack),
      .bus_req    (bus_req),
      .bus_reqtag (bus_reqtag),
      .bus_reqack (bus_reqack),
      .bus_respcyc(bus_respcyc),
      .bus_resp   (bus_resp),
      .bus_resptag(bus_resptag),
      .owner      (owner),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   // ---------------- transaction-level reference model ----------------
   typedef enum int {PH_IDLE, PH_ADDR, PH_WDATA, PH_RDATA} phase_e;
   phase_e m_phase = PH_IDLE;
   int     m_who   = 0;     // 0 = I-cache, 1 = D-cache
   int     m_done  = 0;     // beats transferred so far in this line
   int     m_last  = 1;     // requester granted most recently

   function automatic logic rq_cyc(int k);
      return (k != 0) ? d_reqcyc : i_reqcyc;
   endfunction
   function automatic logic [DW-1:0] rq_data(int k);
      return (k != 0) ? d_req : i_req;
   endfunction
   function automatic logic [TW-1:0] rq_tag(int k);
      return (k != 0) ? d_reqtag : i_reqtag;
   endfunction
   function automatic logic rs_ack(int k);
      return (k != 0) ? d_respack : i_respack;
   endfunction

   task automatic model_reset();
      m_phase = PH_IDLE;
      m_who   = 0;
      m_done  = 0;
      m_last  = 1;
   endtask

   // advance the model by one rising edge using the current inputs
   task automatic model_clock();
      logic [TW-1:0] t;
      int            w;
      case (m_phase)
         PH_IDLE: begin
            if (i_reqcyc || d_reqcyc) begin
               if (i_reqcyc && d_reqcyc) w = RR ? 1 - m_last : 1;
               else                      w = d_reqcyc ? 1 : 0;
               m_who   = w;
               m_last  = w;
               m_done  = 0;
               m_phase = PH_ADDR;
            end
         end
         PH_ADDR: begin
            t = rq_tag(m_who);
            if (!rq_cyc(m_who)) begin
               m_phase = PH_IDLE;
            end else if (bus_reqack) begin
               if (t[TW-1]) begin
                  m_phase = PH_RDATA;
                  m_done  = 0;
               end else begin
                  m_phase = PH_WDATA;
                  m_done  = 1;
               end
            end
         end
         PH_WDATA: begin
            if (rq_cyc(m_who) && bus_reqack) begin
               m_done++;
               if (m_done == BEATS) m_phase = PH_IDLE;
            end
         end
         PH_RDATA: begin
            if (bus_respcyc && rs_ack(m_who)) begin
               m_done++;
               if (m_done == BEATS) m_phase = PH_IDLE;
            end
         end
         default: m_phase = PH_IDLE;
      endcase
   endtask

   // compare every DUT output against what the model says it must be now
   task automatic check_outputs();
      logic          e_bus_reqcyc, e_bus_respack;
      logic [DW-1:0] e_bus_req;
      logic [TW-1:0] e_bus_reqtag;
      logic          e_ack [2];
      logic          e_rcyc[2];
      logic [DW-1:0] e_resp[2];
      logic [TW-1:0] e_rtag[2];
      e_bus_reqcyc  = 1'b0;
      e_bus_respack = 1'b0;
      e_bus_req     = '0;
      e_bus_reqtag  = '0;
      for (int k = 0; k < 2; k++) begin
         e_ack[k]  = 1'b0;
         e_rcyc[k] = 1'b0;
         e_resp[k] = '0;
         e_rtag[k] = '0;
      end
      if (m_phase == PH_ADDR || m_phase == PH_WDATA) begin
         e_bus_reqcyc = rq_cyc(m_who);
         e_bus_req    = rq_data(m_who);
         e_bus_reqtag = rq_tag(m_who);
         e_ack[m_who] = bus_reqack;
      end
      if (m_phase == PH_RDATA) begin
         e_bus_respack = rs_ack(m_who);
         e_rcyc[m_who] = bus_respcyc;
         e_resp[m_who] = bus_resp;
         e_rtag[m_who] = bus_resptag;
      end
      check("busy",        DW'(busy),        DW'(m_phase != PH_IDLE));
      check("owner",       DW'(owner),       DW'(m_who));
      check("bus_reqcyc",  DW'(bus_reqcyc),  DW'(e_bus_reqcyc));
      check("bus_req",     bus_req,          e_bus_req);
      check("bus_reqtag",  DW'(bus_reqtag),  DW'(e_bus_reqtag));
      check("bus_respack", DW'(bus_respack), DW'(e_bus_respack));
      check("i_reqack",    DW'(i_reqack),    DW'(e_ack[0]));
      check("i_respcyc",   DW'(i_respcyc),   DW'(e_rcyc[0]));
      check("i_resp",      i_resp,           e_resp[0]);
      check("i_resptag",   DW'(i_resptag),   DW'(e_rtag[0]));
      check("d_reqack",    DW'(d_reqack),    DW'(e_ack[1]));
      check("d_respcyc",   DW'(d_respcyc),   DW'(e_rcyc[1]));
      check("d_resp",      d_resp,           e_resp[1]);
      check("d_resptag",   DW'(d_resptag),   DW'(e_rtag[1]));
   endtask

   // observations of what actually crossed each interface
   logic [DW-1:0] i_got[$];
   logic [DW-1:0] d_got[$];
   logic [DW-1:0] wq[$];
   int            i_rc_seen = 0;
   int            d_rc_seen = 0;

   task automatic clear_obs();
      i_got.delete();
      d_got.delete();
      wq.delete();
      i_rc_seen = 0;
      d_rc_seen = 0;
   endtask

   // one clock: check at the falling edge, advance the model at the rising edge
   task automatic step();
      @(negedge clk);
      check_outputs();
      if (i_respcyc && i_respack)   i_got.push_back(i_resp);
      if (d_respcyc && d_respack)   d_got.push_back(d_resp);
      if (bus_reqcyc && bus_reqack) wq.push_back(bus_req);
      if (i_respcyc) i_rc_seen++;
      if (d_respcyc) d_rc_seen++;
      @(posedge clk);
      if (reset) model_clock();
      #1;
   endtask

   task automatic idle_inputs();
      i_reqcyc    = 1'b0; i_respack = 1'b0; i_req = '0; i_reqtag = '0;
      d_reqcyc    = 1'b0; d_respack = 1'b0; d_req = '0; d_reqtag = '0;
      bus_reqack  = 1'b0; bus_respcyc = 1'b0; bus_resp = '0; bus_resptag = '0;
   endtask

   int exp_g;
   int hold;
   int guard;
   int n;

   initial begin
      reset = 1'b0;
      idle_inputs();
      model_reset();
      step();
      step();
      @(posedge clk);
      #1;
      reset = 1'b1;
      step();

      // I-cache read alone, bus accepts on the third cycle, 8 response beats
      clear_obs();
      i_reqcyc = 1'b1; i_req = 64'h1000_0040; i_reqtag = 13'h1100;
      step();
      check("r028_owner", DW'(owner), DW'(0));
      step();
      step();
      bus_reqack = 1'b1;
      step();
      bus_reqack = 1'b0; i_reqcyc = 1'b0; i_respack = 1'b1;
      for (int k = 0; k < BEATS; k++) begin
         bus_respcyc = 1'b1; bus_resp = DW'(64'hA000 + k); bus_resptag = 13'h1100;
         step();
      end
      bus_respcyc = 1'b0; i_respack = 1'b0;
      check("r028_busy_after_last", DW'(busy), DW'(0));
      check("r028_beats", DW'(i_got.size()), DW'(BEATS));
      for (int k = 0; k < i_got.size(); k++) check("r028_order", i_got[k], DW'(64'hA000 + k));
      check("r028_no_d_resp", DW'(d_rc_seen), DW'(0));
      step();

      // simultaneous requests four times; the owner withdraws in REQ each time
      for (int r = 0; r < 4; r++) begin
         i_reqcyc = 1'b1; d_reqcyc = 1'b1;
         i_reqtag = 13'h1000; d_reqtag = 13'h1000;
         step();
         exp_g = RR ? ((r % 2 == 0) ? 1 : 0) : 1;
         check("r030_grant", DW'(owner), DW'(exp_g));
         i_reqcyc = 1'b0; d_reqcyc = 1'b0;
         step();
         check("r030_back_idle", DW'(busy), DW'(0));
      end

      // D-cache write, 8 data beats each acknowledged immediately
      clear_obs();
      d_reqcyc = 1'b1; d_reqtag = 13'h0100; d_req = 64'hD000;
      step();
      for (int k = 0; k < BEATS; k++) begin
         d_req = DW'(64'hD000 + k); bus_reqack = 1'b1;
         step();
      end
      d_reqcyc = 1'b0; bus_reqack = 1'b0;
      check("r029_idle", DW'(busy), DW'(0));
      check("r029_beats", DW'(wq.size()), DW'(BEATS));
      for (int k = 0; k < wq.size(); k++) check("r029_data", wq[k], DW'(64'hD000 + k));
      check("r029_no_d_resp", DW'(d_rc_seen), DW'(0));
      step();

      // D-cache read with response gaps and ack withheld for two cycles on beat 3
      clear_obs();
      d_reqcyc = 1'b1; d_reqtag = 13'h1ABC; d_req = 64'h2000;
      step();
      bus_reqack = 1'b1;
      step();
      bus_reqack = 1'b0; d_reqcyc = 1'b0; i_respack = 1'b1;
      n = 0; hold = 0; guard = 0;
      while (n < BEATS && guard < 100) begin
         bus_respcyc = (guard % 3 != 1);
         bus_resp    = DW'(64'hB000 + n);
         bus_resptag = 13'h1ABC;
         d_respack   = 1'b1;
         if (bus_respcyc && n == 3 && hold < 2) begin
            d_respack = 1'b0;
            hold++;
         end
         step();
         if (bus_respcyc && d_respack) n++;
         guard++;
      end
      bus_respcyc = 1'b0; d_respack = 1'b0; i_respack = 1'b0;
      check("r031_in_time", DW'(guard < 100), DW'(1));
      check("r031_beats", DW'(d_got.size()), DW'(BEATS));
      for (int k = 0; k < d_got.size(); k++) check("r031_order", d_got[k], DW'(64'hB000 + k));
      check("r031_non_owner", DW'(i_rc_seen), DW'(0));
      check("r031_idle", DW'(busy), DW'(0));
      step();

      // reset in the middle of beat 4 of an I-cache read
      i_reqcyc = 1'b1; i_reqtag = 13'h1200; i_req = 64'h3000;
      step();
      bus_reqack = 1'b1;
      step();
      bus_reqack = 1'b0; i_respack = 1'b1;
      for (int k = 0; k < 3; k++) begin
         bus_respcyc = 1'b1; bus_resp = DW'(64'hC000 + k);
         step();
      end
      bus_respcyc = 1'b1; bus_resp = 64'hC003; bus_resptag = 13'h1200;
      #2;
      reset = 1'b0;
      #1;
      check("r032_busy",        DW'(busy),        DW'(0));
      check("r032_owner",       DW'(owner),       DW'(0));
      check("r032_i_respcyc",   DW'(i_respcyc),   DW'(0));
      check("r032_i_resp",      i_resp,           DW'(0));
      check("r032_bus_respack", DW'(bus_respack), DW'(0));
      model_reset();
      step();
      step();
      reset = 1'b1;
      bus_respcyc = 1'b0; i_respack = 1'b0;
      i_reqcyc = 1'b1; d_reqcyc = 1'b1; d_reqtag = 13'h1000;
      step();
      check("r032_regrant", DW'(owner), DW'(RR ? 0 : 1));
      check("r032_busy_again", DW'(busy), DW'(1));
      i_reqcyc = 1'b0; d_reqcyc = 1'b0;
      step();

      // randomized traffic against the model
      for (int c = 0; c < 1500; c++) begin
         i_reqcyc    = ($urandom_range(0, 99) < 85);
         d_reqcyc    = ($urandom_range(0, 99) < 85);
         i_req       = DW'({$urandom, $urandom});
         d_req       = DW'({$urandom, $urandom});
         i_reqtag    = TW'($urandom);
         d_reqtag    = TW'($urandom);
         i_respack   = ($urandom_range(0, 99) < 80);
         d_respack   = ($urandom_range(0, 99) < 80);
         bus_reqack  = ($urandom_range(0, 99) < 50);
         bus_respcyc = ($urandom_range(0, 99) < 70);
         bus_resp    = DW'({$urandom, $urandom});
         bus_resptag = TW'($urandom);
         step();
      end
      idle_inputs();
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
